// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the fetch queue: control-transfer opcodes, the
// default empty-slot instruction, the stored entry layout and small helpers.
package fetch_queue_pkg;

  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;

  // RV32I addi x0,x0,0
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h00000013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        is_branch;
  } fq_entry_t;

  function automatic logic is_ctrl_xfer(input logic [31:0] instr);
    logic result;
    case (instr[6:0])
      OPC_BRANCH: result = 1'b1;
      OPC_JAL:    result = 1'b1;
      OPC_JALR:   result = 1'b1;
      default:    result = 1'b0;
    endcase
    return result;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[16]) begin
      return 16'hFFFF;
    end else begin
      return sum[15:0];
    end
  endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: one synchronous write port and one
// combinational read port. Contents are deliberately left unreset.
module fetch_queue_mem
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  fq_entry_t       wr_data,
  input  logic [AW-1:0]   rd_addr,
  output fq_entry_t       rd_data
);

  fq_entry_t mem_q [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read port
  always_comb begin
    rd_data = mem_q[rd_addr];
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling FIFO with flush-on-redirect, opcode predecode
// and a saturating count of words discarded by flushes.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_pc,
  input  logic [31:0]                in_instr,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_instr,
  output logic                       out_is_branch,
  output logic [$clog2(DEPTH):0]     count,
  output logic [15:0]                drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   drop_count_q, drop_count_d;

  logic      push;
  logic      pop;
  fq_entry_t wr_entry;
  fq_entry_t head;

  // Handshake status depends only on registered occupancy
  always_comb begin
    out_valid = (count_q != {CW{1'b0}});
    in_ready  = (count_q != DEPTH_C);
    push      = in_valid & in_ready & ~flush;
    pop       = out_valid & out_ready & ~flush;
  end

  // Predecode the incoming word before it is stored
  always_comb begin
    wr_entry.pc        = in_pc;
    wr_entry.instr     = in_instr;
    wr_entry.is_branch = is_ctrl_xfer(in_instr);
  end

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr_q),
    .rd_data (head)
  );

  // Next-state: flush overrides any push/pop in the same cycle
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    drop_count_d = drop_count_q;
    if (flush) begin
      wr_ptr_d     = {AW{1'b0}};
      rd_ptr_d     = {AW{1'b0}};
      count_d      = {CW{1'b0}};
      drop_count_d = sat_add16(drop_count_q, 16'(count_q));
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= {AW{1'b0}};
      rd_ptr_q     <= {AW{1'b0}};
      count_q      <= {CW{1'b0}};
      drop_count_q <= 16'h0000;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Head outputs; an empty queue presents a NOP at pc 0
  always_comb begin
    if (out_valid) begin
      out_pc        = head.pc;
      out_instr     = head.instr;
      out_is_branch = head.is_branch;
    end else begin
      out_pc        = 32'h00000000;
      out_instr     = NOP_INSTR;
      out_is_branch = 1'b0;
    end
  end

  always_comb begin
    count      = count_q;
    drop_count = drop_count_q;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: stimulus queues expected head entries,
// a negedge monitor pops and compares them whenever decode takes a word.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_is_branch;
  logic [2:0]  count;
  logic [15:0] drop_count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        br;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  int   m_count;
  int   m_drop;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_pc         (in_pc),
    .in_instr      (in_instr),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .out_is_branch (out_is_branch),
    .count         (count),
    .drop_count    (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a word is consumed at the coming edge, compare it with the oldest expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && out_valid && out_ready && !flush) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop actual_pc=%h expected=none", out_pc);
      end else begin
        e = exp_q.pop_front();
        chk("head_pc", out_pc, e.pc);
        chk("head_instr", out_instr, e.instr);
        chk("head_is_branch", {31'd0, out_is_branch}, {31'd0, e.br});
      end
    end
  end

  // One clock of stimulus; the bench's own occupancy model decides acceptance
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                      input logic br, input logic rdy, input logic fl);
    logic push_m;
    logic pop_m;
    exp_t e;
    in_valid  = v;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = rdy;
    flush     = fl;
    push_m = v && (m_count != DEPTH) && !fl;
    pop_m  = (m_count != 0) && rdy && !fl;
    if (push_m) begin
      e.pc = pc; e.instr = ins; e.br = br;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (fl) begin
      m_drop  = (m_drop + m_count > 65535) ? 65535 : m_drop + m_count;
      m_count = 0;
      exp_q.delete();
    end else begin
      m_count = m_count + (push_m ? 1 : 0) - (pop_m ? 1 : 0);
    end
    chk("count", {29'd0, count}, m_count);
    chk("out_valid", {31'd0, out_valid}, (m_count != 0) ? 32'd1 : 32'd0);
    chk("in_ready", {31'd0, in_ready}, (m_count != DEPTH) ? 32'd1 : 32'd0);
    chk("drop_count", {16'd0, drop_count}, m_drop);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_pc = 32'h0; in_instr = 32'h0; out_ready = 1'b0; flush = 1'b0;
  endtask

  logic [31:0] br_instr [4];
  logic        br_exp   [4];

  initial begin
    checks = 0; errors = 0; m_count = 0; m_drop = 0;
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h00000013);
    chk("rst_is_branch", {31'd0, out_is_branch}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_drop", {16'd0, drop_count}, 32'd0);

    // Single push visible one edge later
    step(1'b1, 32'h0, 32'h00500093, 1'b0, 1'b0, 1'b0);
    chk("t1_out_pc", out_pc, 32'h0);
    chk("t1_out_instr", out_instr, 32'h00500093);
    chk("t1_count", {29'd0, count}, 32'd1);
    chk("t1_is_branch", {31'd0, out_is_branch}, 32'd0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Fill to full, extra push ignored, drain in order
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'(i * 4), 32'h00100093 + 32'(i << 20), 1'b0, 1'b0, 1'b0);
    end
    chk("full_count", {29'd0, count}, 32'd4);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    end
    chk("drained_count", {29'd0, count}, 32'd0);
    chk("drained_instr", out_instr, 32'h00000013);

    // Streaming push+pop across pointer wrap
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h100 + 32'(i * 4), 32'h00000093 + 32'(i << 7), 1'b0, 1'b1, 1'b0);
      chk("stream_count", {29'd0, count}, 32'd1);
    end
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Flush with 3 entries and a same-cycle push
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h200 + 32'(i * 4), 32'h00000033, 1'b0, 1'b0, 1'b0);
    end
    step(1'b1, 32'h20, 32'h00000033, 1'b0, 1'b1, 1'b1);
    chk("flush_drop", {16'd0, drop_count}, 32'd3);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Predecode of control-transfer opcodes
    br_instr[0] = 32'h00000463; br_exp[0] = 1'b1;
    br_instr[1] = 32'h0000006F; br_exp[1] = 1'b1;
    br_instr[2] = 32'h00008067; br_exp[2] = 1'b1;
    br_instr[3] = 32'h00000013; br_exp[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'h400 + 32'(i * 4), br_instr[i], br_exp[i], 1'b0, 1'b0);
    end
    chk("beq_head_is_branch", {31'd0, out_is_branch}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    end

    // Asynchronous reset mid-cycle with 2 entries held
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 32'h300 + 32'(i * 4), 32'h00000093, 1'b0, 1'b0, 1'b0);
    end
    idle_inputs();
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_count", {29'd0, count}, 32'd0);
    chk("async_rst_drop", {16'd0, drop_count}, 32'd0);
    exp_q.delete();
    m_count = 0;
    m_drop  = 0;
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_drop", {16'd0, drop_count}, 32'd0);

    // Normal operation resumes after reset
    step(1'b1, 32'h500, 32'h0000006F, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    idle_inputs();
    @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
